rgb_pattern_player: RTL and testbench

Programmable sequencer that drives the board RGB LED through a small table of {color, dwell} entries. It replaces the fixed red→green→blue stepping with timed playback, pause/resume, and manual single-step. Upstream logic supplies already-debounced, edge-detected `step` and `clear` pulses plus a `run` level. A host-side write port reconfigures the table at any time.

---
 rtl/rgb_pattern_player.sv | 142 ++++++++++++++
 tb/tb_rgb_pattern_player.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_pattern_player.sv
// Timed RGB LED sequencer: plays a writable {color, dwell} table with
// pause/resume, manual single-step and clear back to idle.
module rgb_pattern_player #(
    parameter int TICK_DIV = 12000,
    parameter int N_STEPS  = 4,
    parameter int DWELL_W  = 8,
    localparam int IW      = $clog2(N_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               clear,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_addr,
    input  logic [2:0]         cfg_color,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [2:0]         rgb,
    output logic               busy,
    output logic [IW-1:0]      step_idx,
    output logic               wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n, nidx, load_addr;
    logic [DWELL_W-1:0] dwell_cnt, dwell_n, load_dwell;
    logic [PW-1:0]      presc, presc_n;
    logic               wrap_q, wrap_n;
    logic               advance, tick;

    logic [2:0]         color_tbl [N_STEPS];
    logic [DWELL_W-1:0] dwell_tbl [N_STEPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STEPS; i++) begin
                color_tbl[i] <= (i == 0) ? 3'b100 :
                                (i == 1) ? 3'b010 :
                                (i == 2) ? 3'b001 : 3'b111;
                dwell_tbl[i] <= DWELL_W'(1);
            end
        end else if (cfg_we) begin
            color_tbl[cfg_addr] <= cfg_color;
            dwell_tbl[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            presc     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            dwell_cnt <= dwell_n;
            presc     <= presc_n;
            wrap_q    <= wrap_n;
        end
    end

    assign nidx      = idx + 1'b1;
    assign tick      = (presc == TICK_LAST);
    assign load_addr = (state == S_IDLE) ? '0 : nidx;
    // A write landing on the entry being loaded wins over the stored dwell.
    assign load_dwell = (cfg_we && cfg_addr == load_addr) ? cfg_dwell : dwell_tbl[load_addr];

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dwell_n = dwell_cnt;
        presc_n = presc;
        wrap_n  = 1'b0;
        advance = 1'b0;

        case (state)
            S_IDLE: begin
                idx_n   = '0;
                dwell_n = '0;
                presc_n = '0;
                if (run) begin
                    state_n = S_PLAY;
                    dwell_n = load_dwell;
                end
            end
            S_PLAY: begin
                if (step) begin
                    advance = 1'b1;
                end else if (tick) begin
                    presc_n = '0;
                    if (dwell_cnt == DWELL_W'(1))
                        advance = 1'b1;
                    else if (dwell_cnt > DWELL_W'(1))
                        dwell_n = dwell_cnt - 1'b1;
                end else begin
                    presc_n = presc + 1'b1;
                end
                if (!run)
                    state_n = S_PAUSE;
            end
            S_PAUSE: begin
                if (step)
                    advance = 1'b1;
                if (run)
                    state_n = S_PLAY;
            end
            default: state_n = S_IDLE;
        endcase

        if (advance) begin
            idx_n   = nidx;
            dwell_n = load_dwell;
            presc_n = '0;
            wrap_n  = (nidx == '0);
        end

        if (clear) begin
            state_n = S_IDLE;
            idx_n   = '0;
            dwell_n = '0;
            presc_n = '0;
            wrap_n  = 1'b0;
        end
    end

    assign rgb      = (state == S_IDLE) ? 3'b000 : color_tbl[idx];
    assign busy     = (state != S_IDLE);
    assign step_idx = idx;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_rgb_pattern_player.sv
// Scoreboard bench for rgb_pattern_player with TICK_DIV=4 and the default
// four-entry table; each drive pushes the expected outputs for the next edge.
module tb_rgb_pattern_player;

    localparam int TICK_DIV = 4;
    localparam int N_STEPS  = 4;
    localparam int DWELL_W  = 8;
    localparam int IW       = $clog2(N_STEPS);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               run = 1'b0;
    logic               step = 1'b0;
    logic               clear = 1'b0;
    logic               cfg_we = 1'b0;
    logic [IW-1:0]      cfg_addr = '0;
    logic [2:0]         cfg_color = '0;
    logic [DWELL_W-1:0] cfg_dwell = '0;
    logic [2:0]         rgb;
    logic               busy;
    logic [IW-1:0]      step_idx;
    logic               wrap;

    typedef struct {
        int rgb;
        int idx;
        int busy;
        int wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rgb_pattern_player #(
        .TICK_DIV (TICK_DIV),
        .N_STEPS  (N_STEPS),
        .DWELL_W  (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .clear     (clear),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_color (cfg_color),
        .cfg_dwell (cfg_dwell),
        .rgb       (rgb),
        .busy      (busy),
        .step_idx  (step_idx),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive inputs for one edge, push the expectation, then pop and compare after the edge.
    task automatic drive(input logic r, input logic s, input logic c,
                         input int e_rgb, input int e_idx, input int e_busy, input int e_wrap,
                         input string tag);
        exp_t e;
        exp_t got;
        run   = r;
        step  = s;
        clear = c;
        e.rgb = e_rgb; e.idx = e_idx; e.busy = e_busy; e.wrap = e_wrap;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step  = 1'b0;
        clear = 1'b0;
        if (exp_q.size() == 0) begin
            check_eq({tag, " queue"}, 0, 1);
        end else begin
            got = exp_q.pop_front();
            check_eq({tag, " rgb"},  int'(rgb),      got.rgb);
            check_eq({tag, " idx"},  int'(step_idx), got.idx);
            check_eq({tag, " busy"}, int'(busy),     got.busy);
            check_eq({tag, " wrap"}, int'(wrap),     got.wrap);
        end
    endtask

    task automatic cfg_write(input int a, input int col, input int dw);
        cfg_we    = 1'b1;
        cfg_addr  = IW'(a);
        cfg_color = 3'(col);
        cfg_dwell = DWELL_W'(dw);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    function automatic int dflt_color(input int i);
        case (i)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    initial begin
        // Reset with run high: everything stays at zero.
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, "rst0");
        drive(1, 1, 0, 0, 0, 0, 0, "rst1");
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, "idle");
        drive(0, 1, 0, 0, 0, 0, 0, "idle_step");

        // Default playback, 4 cycles per entry, wrap on 111 -> 100.
        for (int i = 0; i < 20; i++)
            drive(1, 0, 0, dflt_color((i / 4) % 4), (i / 4) % 4, 1, (i == 16) ? 1 : 0, "play");
        drive(0, 0, 1, 0, 0, 0, 0, "clear1");

        // Entry 0 dwell 3 with a 7-cycle pause: shown for 19 cycles.
        cfg_write(0, 3'b100, 3);
        for (int j = 0; j < 23; j++)
            drive((j < 5 || j > 11) ? 1'b1 : 1'b0, 0, 0,
                  (j <= 18) ? 3'b100 : 3'b010, (j <= 18) ? 0 : 1, 1, 0, "pause");
        drive(0, 0, 1, 0, 0, 0, 0, "clear2");
        cfg_write(0, 3'b100, 1);

        // Manual stepping in PAUSE, through idx 2 -> 3 -> 0.
        drive(1, 0, 0, 3'b100, 0, 1, 0, "ms_start");
        drive(0, 0, 0, 3'b100, 0, 1, 0, "ms_pause");
        drive(0, 1, 0, 3'b010, 1, 1, 0, "ms_s1");
        drive(0, 1, 0, 3'b001, 2, 1, 0, "ms_s2");
        drive(0, 1, 0, 3'b111, 3, 1, 0, "ms_s3");
        drive(0, 1, 0, 3'b100, 0, 1, 1, "ms_s4");
        drive(0, 0, 0, 3'b100, 0, 1, 0, "ms_hold");
        drive(0, 0, 1, 0, 0, 0, 0, "clear3");

        // Entry 1 dwell 0 holds until a step.
        cfg_write(1, 3'b010, 0);
        for (int j = 0; j < 104; j++)
            drive(1, 0, 0, (j < 4) ? 3'b100 : 3'b010, (j < 4) ? 0 : 1, 1, 0, "hold");
        for (int j = 0; j < 5; j++)
            drive(1, (j == 0) ? 1'b1 : 1'b0, 0, (j < 4) ? 3'b001 : 3'b111, (j < 4) ? 2 : 3, 1, 0, "hold_step");
        drive(0, 0, 1, 0, 0, 0, 0, "clear4");
        cfg_write(1, 3'b010, 1);

        // Step coinciding with tick expiry advances once.
        for (int j = 0; j < 8; j++)
            drive(1, (j == 3) ? 1'b1 : 1'b0, 0,
                  (j < 3) ? 3'b100 : (j < 7) ? 3'b010 : 3'b001,
                  (j < 3) ? 0 : (j < 7) ? 1 : 2, 1, 0, "coll");
        drive(1, 1, 1, 0, 0, 0, 0, "clr_step");
        drive(0, 0, 0, 0, 0, 0, 0, "clr_after");

        // Live rewrite of the active entry; dwell counter keeps running.
        for (int j = 0; j < 10; j++) begin
            if (j == 5) begin
                cfg_we = 1'b1; cfg_addr = 2'd1; cfg_color = 3'b110; cfg_dwell = 8'd3;
            end
            drive(1, 0, 0,
                  (j < 4) ? 3'b100 : (j == 4) ? 3'b010 : (j < 8) ? 3'b110 : 3'b001,
                  (j < 4) ? 0 : (j < 8) ? 1 : 2, 1, 0, "reconf");
            cfg_we = 1'b0;
        end
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, "rst_mid");
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, "rst_idle");
        for (int j = 0; j < 9; j++)
            drive(1, 0, 0, (j < 4) ? 3'b100 : (j < 8) ? 3'b010 : 3'b001,
                  (j < 4) ? 0 : (j < 8) ? 1 : 2, 1, 0, "restored");
        drive(0, 0, 1, 0, 0, 0, 0, "clear5");

        check_eq("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
